// File: rtl/uart_rx_deser.sv
// UART 8N1 receiver with a one-entry valid/ready holding register and error pulses.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 104,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
`endif

    state_t state, next_state;

    logic             sync_p0;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shreg;
    logic             sample_bit;
    logic             done;
    logic             bad_frame;
    logic             frame_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_sample;
    assign frame_bad = !rxs || par_bad;
`else
    assign frame_bad = !rxs;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sample_bit = 1'b0;
        done       = 1'b0;
        bad_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxs) next_state = S_START;
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            S_START: begin
                if (cnt == HALF) next_state = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt == LAST) begin
                    sample_bit = 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == LAST) begin
                    par_sample = 1'b1;
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == LAST) begin
                    if (frame_bad) bad_frame = 1'b1;
                    else           done      = 1'b1;
                    next_state = rxs ? S_IDLE : S_BRK;
                end
            end
            // Hold here while the line stays low so a break cannot look like a new start bit.
            S_BRK: begin
                if (rxs) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0   <= 1'b1;
            rxs       <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            sync_p0 <= RX;
            rxs     <= sync_p0;

            if (next_state != state || cnt == LAST || state == S_IDLE || state == S_BRK) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (sample_bit) begin
                shreg <= {rxs, shreg[WIDTH-1:1]};
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

`ifdef UART_RX_PARITY_EN
            if (par_sample) par_bad <= (^shreg) ^ rxs;
`endif

            frame_err <= bad_frame;
            overrun   <= done && rx_valid && !rx_ready;

            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
